// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI responder peripheral.
package spi_slave_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned CTRL_W = 5;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_TXDATA = 4'h4;
  localparam logic [3:0] ADDR_RXDATA = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_CPOL = 1;
  localparam int unsigned CTRL_CPHA = 2;
  localparam int unsigned CTRL_RXIE = 3;
  localparam int unsigned CTRL_OVIE = 4;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_RXV  = 1;
  localparam int unsigned ST_OVR  = 2;
  localparam int unsigned ST_TXE  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pad input with rise/fall pulses
// derived from the last two synchronized samples.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = q & ~prev_q;
  assign fall_c = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCK/SS/MOSI, 8-bit MSB-first frames in all CPOL/CPHA
// modes, single-entry TX/RX buffers behind the peripheral register bus.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BUS_W-1:0] data_i,
  input  logic [BUS_W-1:0] addr_i,
  input  logic             we_i,
  output logic [BUS_W-1:0] data_o,
  input  logic             spi_sck,
  input  logic             spi_ss_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             irq_o
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [DATA_W-1:0]   txbuf_q, rxdata_q, shifter_q;
  logic                tx_empty_q, rx_valid_q, overrun_q;
  logic [CNT_W-1:0]    bitcnt_q;
  logic                cpol_q, cpha_q;
  logic                miso_q, miso_oe_q, irq_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic sck_s, sck_rise_c, sck_fall_c;
  logic ss_s, ss_rise_c, ss_fall_c;
  logic mosi_s;
  logic lead_c, trail_c;
  logic start_c, sample_c, drive_c, frame_done_c;
  logic wr_ctrl_c, wr_tx_c, wr_status_c;
  logic [DATA_W-1:0] tx_next_c;
  logic unused_bits;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_ni(rst_ni), .d(spi_sck),
    .q(sck_s), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i(clk_i), .rst_ni(rst_ni), .d(spi_ss_n),
    .q(ss_s), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
  );

  // MOSI only needs to be aligned with the synchronized SCK edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mosi_sync_q <= '0;
    else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign lead_c    = cpol_q ? sck_fall_c : sck_rise_c;
  assign trail_c   = cpol_q ? sck_rise_c : sck_fall_c;
  assign tx_next_c = tx_empty_q ? IDLE_TX : txbuf_q;

  assign wr_ctrl_c   = we_i && (addr_i[3:0] == ADDR_CTRL);
  assign wr_tx_c     = we_i && (addr_i[3:0] == ADDR_TXDATA);
  assign wr_status_c = we_i && (addr_i[3:0] == ADDR_STATUS);
  assign unused_bits = &{1'b0, addr_i[BUS_W-1:4], data_i[BUS_W-1:DATA_W], sck_s, ss_s};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    sample_c = 1'b0;
    drive_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall_c && ctrl_q[CTRL_EN]) begin
          state_d = ACTIVE;
          start_c = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise_c || !ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else begin
          sample_c = cpha_q ? trail_c : lead_c;
          drive_c  = cpha_q ? lead_c : trail_c;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_done_c = sample_c && (bitcnt_q == CNT_W'(DATA_W - 1));
  end

  // Later assignments win: frame completion over W1C, TXDATA write over load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      txbuf_q    <= '0;
      rxdata_q   <= '0;
      shifter_q  <= '0;
      tx_empty_q <= 1'b1;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      bitcnt_q   <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_ctrl_c) ctrl_q <= data_i[CTRL_W-1:0];
      if (wr_status_c) begin
        if (data_i[ST_RXV]) rx_valid_q <= 1'b0;
        if (data_i[ST_OVR]) overrun_q  <= 1'b0;
      end
      if (start_c) begin
        shifter_q  <= tx_next_c;
        tx_empty_q <= 1'b1;
        bitcnt_q   <= '0;
        cpol_q     <= ctrl_q[CTRL_CPOL];
        cpha_q     <= ctrl_q[CTRL_CPHA];
        if (!ctrl_q[CTRL_CPHA]) miso_q <= tx_next_c[DATA_W-1];
      end
      if (sample_c) begin
        bitcnt_q <= bitcnt_q + CNT_W'(1);
        if (frame_done_c) begin
          rxdata_q   <= {shifter_q[DATA_W-2:0], mosi_s};
          rx_valid_q <= 1'b1;
          if (rx_valid_q) overrun_q <= 1'b1;
          shifter_q  <= tx_next_c;
          tx_empty_q <= 1'b1;
        end else begin
          shifter_q <= {shifter_q[DATA_W-2:0], mosi_s};
        end
      end
      if (drive_c) miso_q <= shifter_q[DATA_W-1];
      if (wr_tx_c) begin
        txbuf_q    <= data_i[DATA_W-1:0];
        tx_empty_q <= 1'b0;
      end
      miso_oe_q <= (state_d == ACTIVE);
      irq_q     <= (rx_valid_q & ctrl_q[CTRL_RXIE]) | (overrun_q & ctrl_q[CTRL_OVIE]);
    end
  end

  always_comb begin
    data_o = '0;
    case (addr_i[3:0])
      ADDR_CTRL:   data_o = BUS_W'(ctrl_q);
      ADDR_TXDATA: data_o = BUS_W'(txbuf_q);
      ADDR_RXDATA: data_o = BUS_W'(rxdata_q);
      ADDR_STATUS: data_o = BUS_W'({tx_empty_q, overrun_q, rx_valid_q, state_q == ACTIVE});
      default:     data_o = '0;
    endcase
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bus/SPI master pushes expected values, a
// negedge monitor pops them as register reads and MISO bytes appear.
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] data_o;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, irq;

  always #5 clk_i = ~clk_i;

  spi_slave dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .addr_i(addr_i), .we_i(we_i),
    .data_o(data_o), .spi_sck(sck), .spi_ss_n(ss_n), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(miso_oe), .irq_o(irq)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_stb = 1'b0;
  logic miso_smp = 1'b0;
  int   chk_kind = 0;
  logic [7:0] mon_shift = '0;
  int   mon_bits = 0;

  task automatic score(input logic [31:0] act);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: got 0x%0h with no expectation queued", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk_i) begin
    if (miso_smp) begin
      mon_shift = {mon_shift[6:0], miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        score(32'(mon_shift));
      end
    end
    if (chk_stb) begin
      case (chk_kind)
        0:       score(data_o);
        1:       score(32'(irq));
        2:       score(32'(miso_oe));
        default: score(32'(miso));
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr_i = 32'(a);
    data_i = d;
    we_i   = 1'b1;
    tick(1);
    we_i   = 1'b0;
  endtask

  task automatic check(input int kind, input logic [3:0] a, input logic [31:0] expv,
                       input string name);
    exp_q.push_back('{name, expv});
    addr_i   = 32'(a);
    chk_kind = kind;
    chk_stb  = 1'b1;
    tick(1);
    chk_stb  = 1'b0;
  endtask

  task automatic xfer(input logic [1:0] mode, input logic [7:0] mb,
                      input logic [7:0] exp_miso, input bit keep_ss);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    exp_q.push_back('{"miso_byte", 32'(exp_miso)});
    ss_n = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!cpha) begin
        mosi = mb[i];
        tick(8);
        sck = ~cpol;
        miso_smp = 1'b1;
        tick(1);
        miso_smp = 1'b0;
        tick(7);
        sck = cpol;
      end else begin
        tick(8);
        sck  = ~cpol;
        mosi = mb[i];
        tick(8);
        sck = cpol;
        miso_smp = 1'b1;
        tick(1);
        miso_smp = 1'b0;
      end
    end
    if (!keep_ss) begin
      tick(8);
      ss_n = 1'b1;
      tick(8);
    end
  endtask

  // Mode-0 partial frame, leaves SS asserted and does not feed the monitor.
  task automatic partial0(input logic [7:0] mb, input int nbits);
    ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mb[7-i];
      tick(8);
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] mode;
    int wait_cnt;

    tick(3);
    rst_ni = 1'b1;
    tick(2);
    check(0, ADDR_STATUS, 32'h8, "rst_status");
    check(0, ADDR_CTRL,   32'h0, "rst_ctrl");
    check(0, ADDR_RXDATA, 32'h0, "rst_rxdata");
    check(1, 4'h0, 32'h0, "rst_irq");
    check(2, 4'h0, 32'h0, "rst_miso_oe");
    check(3, 4'h0, 32'h0, "rst_miso");
    wr(4'h1, 32'hFFFF_FFFF);
    check(0, 4'h1,      32'h0, "unmapped_read");
    check(0, ADDR_CTRL, 32'h0, "unmapped_write_ignored");

    // Mode 0 basic exchange
    wr(ADDR_CTRL, 32'h9);
    wr(ADDR_TXDATA, 32'hA5);
    check(0, ADDR_TXDATA, 32'hA5, "txdata_readback");
    check(0, ADDR_STATUS, 32'h0, "status_tx_loaded");
    xfer(2'd0, 8'h3C, 8'hA5, 1'b0);
    tick(4);
    check(0, ADDR_RXDATA, 32'h3C, "m0_rxdata");
    check(0, ADDR_STATUS, 32'hA, "m0_status");
    check(1, 4'h0, 32'h1, "m0_irq");
    check(2, 4'h0, 32'h0, "m0_oe_idle");
    wr(ADDR_STATUS, 32'h2);
    tick(2);
    check(0, ADDR_STATUS, 32'h8, "w1c_rx_valid");

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      sck  = mode[1];
      tick(4);
      wr(ADDR_CTRL, 32'h9 | (32'(mode[1]) << 1) | (32'(mode[0]) << 2));
      wr(ADDR_TXDATA, 32'h81);
      xfer(mode, 8'h7E, 8'h81, 1'b0);
      tick(4);
      check(0, ADDR_RXDATA, 32'h7E, "mode_rxdata");
      check(2, 4'h0, 32'h0, "mode_oe_idle");
      wr(ADDR_STATUS, 32'h2);
    end
    sck = 1'b0;
    tick(4);
    wr(ADDR_CTRL, 32'h19);

    // Back-to-back frames under continuous SS: overrun
    wr(ADDR_TXDATA, 32'hC3);
    xfer(2'd0, 8'hAA, 8'hC3, 1'b1);
    xfer(2'd0, 8'h55, 8'h00, 1'b0);
    tick(4);
    check(0, ADDR_RXDATA, 32'h55, "ovr_rxdata");
    check(0, ADDR_STATUS, 32'hE, "ovr_status");
    check(1, 4'h0, 32'h1, "ovr_irq");
    wr(ADDR_STATUS, 32'h6);
    tick(3);
    check(0, ADDR_STATUS, 32'h8, "w1c_both");
    check(1, 4'h0, 32'h0, "irq_cleared");

    // TX buffer empty: IDLE_TX shifted out
    xfer(2'd0, 8'h12, 8'h00, 1'b0);
    tick(4);
    check(0, ADDR_RXDATA, 32'h12, "idle_tx_rxdata");
    check(0, ADDR_STATUS, 32'hA, "idle_tx_status");
    wr(ADDR_STATUS, 32'h2);

    // Aborted frame is discarded
    partial0(8'hF0, 5);
    check(0, ADDR_STATUS, 32'h9, "abort_busy");
    ss_n = 1'b1;
    tick(4);
    check(0, ADDR_STATUS, 32'h8, "abort_dropped");
    wr(ADDR_TXDATA, 32'h5A);
    xfer(2'd0, 8'h96, 8'h5A, 1'b0);
    tick(4);
    check(0, ADDR_RXDATA, 32'h96, "after_abort_rxdata");
    check(0, ADDR_STATUS, 32'hA, "after_abort_status");

    // Asynchronous reset mid-frame
    wr(ADDR_TXDATA, 32'h33);
    partial0(8'h0F, 3);
    tick(5);
    check(3, 4'h0, 32'h1, "pre_rst_miso");
    rst_ni = 1'b0;
    check(0, ADDR_STATUS, 32'h8, "midrst_status");
    check(2, 4'h0, 32'h0, "midrst_oe");
    check(3, 4'h0, 32'h0, "midrst_miso");
    check(1, 4'h0, 32'h0, "midrst_irq");
    check(0, ADDR_TXDATA, 32'h0, "midrst_txdata");
    check(0, ADDR_RXDATA, 32'h0, "midrst_rxdata");
    check(0, ADDR_CTRL,   32'h0, "midrst_ctrl");
    ss_n = 1'b1;
    tick(2);
    rst_ni = 1'b1;
    tick(4);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      tick(1);
      wait_cnt++;
    end
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: no output observed, expected 0x%0h", e.name, e.val);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
